// File: rtl/scs8hd_icg_sched.sv
`timescale 1ns/1ps
// Wake/idle scheduler for a bank of latch-based ICG cells: per-domain OFF/PEND/ON/HOLD
// FSMs with registered GATE/ACK, a staggered round-robin wake arbiter and idle hysteresis.

module scs8hd_icg_dom #(
  parameter int IDLE_W = 4
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              req_i,
  input  logic              gnt_i,
  input  logic [IDLE_W-1:0] idle_i,
  output logic              pend_o,
  output logic              gate_o,
  output logic              ack_o,
  output logic              act_o
);
  typedef enum logic [1:0] {OFF, PEND, ON, HOLD} st_e;

  st_e              st_q, st_d;
  logic [IDLE_W-1:0] cnt_q, cnt_d;
  logic             gate_q, gate_d, ack_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      OFF:  if (req_i) st_d = PEND;
      PEND: begin
        if (!req_i)     st_d = OFF;
        else if (gnt_i) st_d = ON;
      end
      ON: if (!req_i) begin
        st_d  = HOLD;
        cnt_d = idle_i;
      end
      HOLD: begin
        // a returning request re-enters ON directly; the clock never stopped
        if (req_i)              st_d  = ON;
        else if (cnt_q == '0)   st_d  = OFF;
        else                    cnt_d = cnt_q - 1'b1;
      end
      default: st_d = OFF;
    endcase
    gate_d = (st_d == ON) || (st_d == HOLD);
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      st_q   <= OFF;
      cnt_q  <= '0;
      gate_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
      ack_q  <= gate_q & gate_d;
    end
  end

  assign pend_o = (st_q == PEND) && req_i;
  assign gate_o = gate_q;
  assign ack_o  = ack_q;
  assign act_o  = (st_q != OFF);
endmodule

module scs8hd_icg_sched #(
  parameter int N       = 4,
  parameter int IDLE_W  = 4,
  parameter int STAGGER = 2
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic [N-1:0]      REQ,
  input  logic [IDLE_W-1:0] IDLE_CYC,
  input  logic              TE,
  output logic [N-1:0]      GATE,
  output logic [N-1:0]      ACK,
  output logic              BUSY
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  logic [N-1:0]  pend, gnt, gate_q, act;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] stg_q;
  logic          gnt_any, busy_q;
  int            idx;

  for (genvar i = 0; i < N; i++) begin : g_dom
    scs8hd_icg_dom #(.IDLE_W(IDLE_W)) u_dom (
      .CLK    (CLK),
      .RESETB (RESETB),
      .req_i  (REQ[i]),
      .gnt_i  (gnt[i]),
      .idle_i (IDLE_CYC),
      .pend_o (pend[i]),
      .gate_o (gate_q[i]),
      .ack_o  (ACK[i]),
      .act_o  (act[i])
    );
  end

  // first live PEND domain at or above the pointer, wrapping; only when stagger expired
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    ptr_d   = ptr_q;
    idx     = 0;
    if (stg_q == '0) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr_q) + k) % N;
        if (!gnt_any && pend[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = PW'((idx + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ptr_q  <= '0;
      stg_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= |act;
      if (gnt_any)            stg_q <= SW'(STAGGER - 1);
      else if (stg_q != '0)   stg_q <= stg_q - 1'b1;
    end
  end

  assign GATE = gate_q | {N{TE}};
  assign BUSY = busy_q;
endmodule

// File: tb/tb_scs8hd_icg_sched.sv
`timescale 1ns/1ps
// Scoreboard bench: expected GATE/ACK/BUSY per edge are queued at stimulus time, checked at negedge.

module tb_scs8hd_icg_sched;
  logic       CLK = 1'b0;
  logic       RESETB, TE;
  logic [3:0] REQ, REQ4, IDLE_CYC;
  logic [3:0] GATE, ACK, GATE4, ACK4;
  logic       BUSY, BUSY4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    bit         d;
    logic [3:0] g;
    logic [3:0] a;
    logic       b;
  } exp_t;
  exp_t sb[$];

  scs8hd_icg_sched #(.N(4), .IDLE_W(4), .STAGGER(2)) u_dut (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ), .IDLE_CYC(IDLE_CYC), .TE(TE),
    .GATE(GATE), .ACK(ACK), .BUSY(BUSY)
  );

  scs8hd_icg_sched #(.N(4), .IDLE_W(4), .STAGGER(4)) u_dut4 (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ4), .IDLE_CYC(IDLE_CYC), .TE(TE),
    .GATE(GATE4), .ACK(ACK4), .BUSY(BUSY4)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // off=1 is the first edge after the current negedge
  task automatic expq(input int off, input bit d, input logic [3:0] g, input logic [3:0] a,
                      input logic b);
    exp_t e;
    e.cyc = cyc + off; e.d = d; e.g = g; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) chk("sb_late", cyc, e.cyc);
      chk($sformatf("gate%0d@%0d", e.d, e.cyc), {28'b0, e.d ? GATE4 : GATE}, {28'b0, e.g});
      chk($sformatf("ack%0d@%0d",  e.d, e.cyc), {28'b0, e.d ? ACK4 : ACK},   {28'b0, e.a});
      chk($sformatf("busy%0d@%0d", e.d, e.cyc), {31'b0, e.d ? BUSY4 : BUSY}, {31'b0, e.b});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    RESETB = 1'b0; TE = 1'b1; REQ = '0; REQ4 = '0; IDLE_CYC = 4'd3;
    #2;
    chk("te_rst_gate",  {28'b0, GATE},  32'hf);
    chk("te_rst_gate4", {28'b0, GATE4}, 32'hf);
    chk("te_rst_ack",   {28'b0, ACK},   32'h0);
    chk("te_rst_busy",  {31'b0, BUSY},  32'h0);
    TE = 1'b0;
    #1 chk("te_off_gate", {28'b0, GATE}, 32'h0);
    @(negedge CLK);
    RESETB = 1'b1;
    step(2);

    // single wake
    REQ = 4'b0001;
    expq(1, 0, 4'b0000, 4'b0000, 1'b0);
    expq(2, 0, 4'b0001, 4'b0000, 1'b1);
    expq(3, 0, 4'b0001, 4'b0001, 1'b1);
    step(4);
    TE = 1'b1;
    #1 chk("te_run_gate", {28'b0, GATE}, 32'hf);
    chk("te_run_ack", {28'b0, ACK}, 32'h1);
    TE = 1'b0;
    #1 chk("te_run_gate_off", {28'b0, GATE}, 32'h1);

    // asynchronous reset mid-cycle, then re-wake from pointer 0
    @(negedge CLK);
    #2 RESETB = 1'b0;
    #1;
    chk("arst_gate", {28'b0, GATE}, 32'h0);
    chk("arst_ack",  {28'b0, ACK},  32'h0);
    chk("arst_busy", {31'b0, BUSY}, 32'h0);
    #1 RESETB = 1'b1;
    expq(1, 0, 4'b0000, 4'b0000, 1'b0);
    expq(2, 0, 4'b0001, 4'b0000, 1'b1);
    expq(3, 0, 4'b0001, 4'b0001, 1'b1);
    step(3);

    // hysteresis 3: GATE falls at h0+4; IDLE_CYC change mid-hold is ignored
    IDLE_CYC = 4'd3; REQ = 4'b0000;
    for (int k = 1; k <= 4; k++) expq(k, 0, 4'b0001, 4'b0001, 1'b1);
    expq(5, 0, 4'b0000, 4'b0000, 1'b1);
    expq(6, 0, 4'b0000, 4'b0000, 1'b0);
    step(1);
    IDLE_CYC = 4'd0;
    step(6);

    // hysteresis with re-request at h0+2: no gap, no re-arbitration
    IDLE_CYC = 4'd3; REQ = 4'b0001;
    expq(1, 0, 4'b0000, 4'b0000, 1'b0);
    expq(2, 0, 4'b0001, 4'b0000, 1'b1);
    expq(3, 0, 4'b0001, 4'b0001, 1'b1);
    step(4);
    REQ = 4'b0000;
    for (int k = 1; k <= 7; k++) expq(k, 0, 4'b0001, 4'b0001, 1'b1);
    step(2);
    REQ = 4'b0001;
    step(6);

    REQ = 4'b0000; IDLE_CYC = 4'd0;
    step(4);
    RESETB = 1'b0;
    step(1);
    RESETB = 1'b1;

    // contention with STAGGER=2
    REQ = 4'b1111;
    expq(1, 0, 4'b0000, 4'b0000, 1'b0);
    expq(2, 0, 4'b0001, 4'b0000, 1'b1);
    expq(3, 0, 4'b0001, 4'b0001, 1'b1);
    expq(4, 0, 4'b0011, 4'b0001, 1'b1);
    expq(5, 0, 4'b0011, 4'b0011, 1'b1);
    expq(6, 0, 4'b0111, 4'b0011, 1'b1);
    expq(7, 0, 4'b0111, 4'b0111, 1'b1);
    expq(8, 0, 4'b1111, 4'b0111, 1'b1);
    expq(9, 0, 4'b1111, 4'b1111, 1'b1);
    step(10);

    // all gate off together after one HOLD cycle
    REQ = 4'b0000;
    expq(1, 0, 4'b1111, 4'b1111, 1'b1);
    expq(2, 0, 4'b0000, 4'b0000, 1'b1);
    expq(3, 0, 4'b0000, 4'b0000, 1'b0);
    step(4);

    // pointer wrapped to 0: domain 1 wins before domain 3
    REQ = 4'b1010;
    expq(1, 0, 4'b0000, 4'b0000, 1'b0);
    expq(2, 0, 4'b0010, 4'b0000, 1'b1);
    expq(3, 0, 4'b0010, 4'b0010, 1'b1);
    expq(4, 0, 4'b1010, 4'b0010, 1'b1);
    expq(5, 0, 4'b1010, 4'b1010, 1'b1);
    step(6);
    REQ = 4'b0000;
    step(4);

    // abandoned request on the STAGGER=4 instance
    REQ4 = 4'b0001;
    expq(1, 1, 4'b0000, 4'b0000, 1'b0);
    expq(2, 1, 4'b0001, 4'b0000, 1'b1);
    for (int k = 3; k <= 6; k++) expq(k, 1, 4'b0001, 4'b0001, 1'b1);
    expq(7, 1, 4'b0011, 4'b0001, 1'b1);
    for (int k = 8; k <= 10; k++) expq(k, 1, 4'b0011, 4'b0011, 1'b1);
    expq(11, 1, 4'b1011, 4'b0011, 1'b1);
    expq(12, 1, 4'b1011, 4'b1011, 1'b1);
    step(2);
    REQ4 = 4'b0011;
    step(1);
    REQ4 = 4'b0001;
    step(2);
    REQ4 = 4'b1011;
    step(8);
    REQ4 = 4'b0000;

    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
